// File: rtl/arb_mux_2x1_rr_if.sv
// Handshake and data bundle between two requesters, the arbiter and the single consumer.
// slave: arbiter side; master: requester/consumer environment side.
interface arb_mux_2x1_rr_if #(
  parameter int W = 8
);
  logic         req0;
  logic [W-1:0] d0;
  logic         last0;
  logic         req1;
  logic [W-1:0] d1;
  logic         last1;
  logic         gnt0;
  logic         gnt1;
  logic         sel;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready;

  modport slave (
    input  req0, d0, last0, req1, d1, last1, out_ready,
    output gnt0, gnt1, sel, out_valid, out_data, out_last
  );

  modport master (
    output req0, d0, last0, req1, d1, last1, out_ready,
    input  gnt0, gnt1, sel, out_valid, out_data, out_last
  );
endinterface

// File: rtl/arb_mux_2x1_rr.sv
// Round-robin 2:1 arbiter/sequencer driving a shared mux onto one valid/ready stream.
// Optional grant-entry counters are enabled with the ARB_STATS_EN macro.
module arb_mux_2x1_rr #(
  parameter int W         = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  arb_mux_2x1_rr_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
`endif
);

  localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = (MAX_BEATS > 0) ? CW'(MAX_BEATS) : '0;
  localparam logic [CW-1:0] CNT_LIM = (MAX_BEATS > 0) ? CW'(MAX_BEATS - 1) : '0;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_n;
  logic          ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          gnt0_q, gnt1_q, sel_q;
  logic          out_valid, xfer, cur_req, oth_req, release_own;

  assign out_valid     = ((state == OWN0) && bus.req0) || ((state == OWN1) && bus.req1);
  assign xfer          = out_valid && bus.out_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = (~{W{sel_q}} & bus.d0) | ({W{sel_q}} & bus.d1);
  assign bus.out_last  = (~sel_q & bus.last0) | (sel_q & bus.last1);
  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.sel       = sel_q;

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    cnt_n       = cnt;
    release_own = 1'b0;
    cur_req     = (state == OWN1) ? bus.req1 : bus.req0;
    oth_req     = (state == OWN1) ? bus.req0 : bus.req1;
    case (state)
      IDLE: begin
        // ptr=0 favours requester 0 on a tie
        if (bus.req0 && (!bus.req1 || !ptr)) state_n = OWN0;
        else if (bus.req1)                   state_n = OWN1;
      end
      default: begin
        if (!cur_req) begin
          release_own = 1'b1;
        end else if (xfer) begin
          if (bus.out_last)                                          release_own = 1'b1;
          else if ((MAX_BEATS != 0) && (cnt >= CNT_LIM) && oth_req)  release_own = 1'b1;
          else if ((MAX_BEATS != 0) && (cnt != CNT_MAX))             cnt_n = cnt + 1'b1;
        end
        if (release_own) begin
          ptr_n   = (state == OWN0);
          cnt_n   = '0;
          state_n = oth_req ? ((state == OWN0) ? OWN1 : OWN0) : IDLE;
        end
      end
    endcase
  end

  // Grant/select flops track the next state so they stay aligned with the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      cnt    <= '0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      sel_q  <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      gnt0_q <= (state_n == OWN0);
      gnt1_q <= (state_n == OWN1);
      sel_q  <= (state_n == OWN1);
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if ((state != OWN0) && (state_n == OWN0) && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if ((state != OWN1) && (state_n == OWN1) && (gnt_cnt1 != '1)) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_arb_mux_2x1_rr.sv
// Directed bench for arb_mux_2x1_rr (W=8, MAX_BEATS=4); inputs change and outputs are sampled on the falling edge.
module tb_arb_mux_2x1_rr;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  arb_mux_2x1_rr_if #(.W(8)) bus ();
`ifdef ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

  arb_mux_2x1_rr #(.W(8), .MAX_BEATS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef ARB_STATS_EN
    ,
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1)
`endif
  );

  task automatic drive_idle;
    bus.req0 = 1'b0; bus.d0 = '0; bus.last0 = 1'b0;
    bus.req1 = 1'b0; bus.d1 = '0; bus.last1 = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic reset_dut;
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.sel, bus.out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state got %b exp 0000", {bus.gnt0, bus.gnt1, bus.sel, bus.out_valid});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    reset_dut();
    bus.req0 = 1'b1; bus.d0 = 8'hA5; bus.last0 = 1'b1; bus.out_ready = 1'b1;
    #1;
    checks++;
    if ({bus.gnt0, bus.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL single_latency got %b exp 00", {bus.gnt0, bus.out_valid});
    end
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.sel, bus.out_valid, bus.out_last} !== 5'b10011) begin
      errors++;
      $display("FAIL single_grant got %b exp 10011", {bus.gnt0, bus.gnt1, bus.sel, bus.out_valid, bus.out_last});
    end
    checks++;
    if (bus.out_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_data got %h exp a5", bus.out_data);
    end
    @(negedge clk);
    bus.req0 = 1'b0;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL single_release got %b exp 000", {bus.gnt0, bus.gnt1, bus.out_valid});
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    reset_dut();
    bus.req0 = 1'b1; bus.d0 = 8'h11; bus.last0 = 1'b1;
    bus.req1 = 1'b1; bus.d1 = 8'h22; bus.last1 = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) bus.req0 = 1'b0;
      #1;
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_d = (i % 2 == 0) ? 8'h11 : 8'h22;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.out_valid} !== {exp_g, 1'b1}) begin
        errors++;
        $display("FAIL rr_grant[%0d] got %b exp %b", i, {bus.gnt0, bus.gnt1, bus.out_valid}, {exp_g, 1'b1});
      end
      checks++;
      if (bus.out_data !== exp_d) begin
        errors++;
        $display("FAIL rr_data[%0d] got %h exp %h", i, bus.out_data, exp_d);
      end
    end
    @(negedge clk);
    bus.req1 = 1'b0;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rr_idle got %b exp 000", {bus.gnt0, bus.gnt1, bus.out_valid});
    end
  endtask

  task automatic test_max_beats;
    logic [7:0] d0_t [11];
    logic [7:0] exp_d;
    logic [2:0] exp_g;
    logic       exp_l;
    d0_t = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    reset_dut();
    bus.req0 = 1'b1; bus.d0 = 8'h01; bus.last0 = 1'b0;
    bus.d1 = 8'hB1; bus.last1 = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.d0    = d0_t[i];
      bus.last0 = (i == 10);
      bus.req1  = (i >= 1 && i <= 4);
      #1;
      exp_g = (i == 4) ? 3'b011 : 3'b100;
      exp_d = (i == 4) ? 8'hB1 : d0_t[i];
      exp_l = (i == 4 || i == 10);
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.sel} !== exp_g) begin
        errors++;
        $display("FAIL maxb_grant[%0d] got %b exp %b", i, {bus.gnt0, bus.gnt1, bus.sel}, exp_g);
      end
      checks++;
      if ({bus.out_valid, bus.out_last, bus.out_data} !== {1'b1, exp_l, exp_d}) begin
        errors++;
        $display("FAIL maxb_beat[%0d] got v%b l%b %h exp v1 l%b %h", i, bus.out_valid, bus.out_last,
                 bus.out_data, exp_l, exp_d);
      end
    end
    @(negedge clk);
    bus.req0 = 1'b0;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL maxb_idle got %b exp 000", {bus.gnt0, bus.gnt1, bus.out_valid});
    end
  endtask

  task automatic test_stall;
    logic [7:0] after_t [3];
    after_t = '{8'h44, 8'h55, 8'h66};
    reset_dut();
    bus.req0 = 1'b1; bus.d0 = 8'h33; bus.last0 = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.gnt0, bus.out_valid, bus.out_data} !== {2'b11, 8'h33}) begin
      errors++;
      $display("FAIL stall_first got g%b v%b %h exp g1 v1 33", bus.gnt0, bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    bus.d0 = 8'h44; bus.out_ready = 1'b0;
    bus.req1 = 1'b1; bus.d1 = 8'h77; bus.last1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.sel, bus.out_valid, bus.out_data} !== {4'b1001, 8'h44}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got %b %h exp 1001 44", i, {bus.gnt0, bus.gnt1, bus.sel, bus.out_valid},
                 bus.out_data);
      end
    end
    // Three more beats must fit before the forced handover if the stall left the count alone.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.d0 = after_t[i];
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.out_data} !== {2'b10, after_t[i]}) begin
        errors++;
        $display("FAIL stall_resume[%0d] got %b %h exp 10 %h", i, {bus.gnt0, bus.gnt1}, bus.out_data, after_t[i]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.gnt1, bus.sel, bus.out_data} !== {2'b11, 8'h77}) begin
      errors++;
      $display("FAIL stall_handover got %b %h exp 11 77", {bus.gnt1, bus.sel}, bus.out_data);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    bus.req1 = 1'b0;
  endtask

  task automatic test_abandon;
    reset_dut();
    bus.req1 = 1'b1; bus.d1 = 8'h77; bus.last1 = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.req0 = 1'b1; bus.d0 = 8'h88; bus.last0 = 1'b1;
    #1;
    checks++;
    if ({bus.gnt1, bus.sel, bus.out_valid, bus.out_data} !== {3'b111, 8'h77}) begin
      errors++;
      $display("FAIL abandon_own1 got %b %h exp 111 77", {bus.gnt1, bus.sel, bus.out_valid}, bus.out_data);
    end
    @(negedge clk);
    bus.req1 = 1'b0;
    #1;
    checks++;
    if ({bus.gnt1, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL abandon_novalid got %b exp 10", {bus.gnt1, bus.out_valid});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.sel, bus.out_valid, bus.out_data} !== {4'b1001, 8'h88}) begin
      errors++;
      $display("FAIL abandon_own0 got %b %h exp 1001 88", {bus.gnt0, bus.gnt1, bus.sel, bus.out_valid},
               bus.out_data);
    end
    @(negedge clk);
    bus.req0 = 1'b0;
  endtask

  task automatic test_reset_mid;
    reset_dut();
    bus.req0 = 1'b1; bus.d0 = 8'h5A; bus.last0 = 1'b1; bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    bus.last0 = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.gnt0, bus.out_valid} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_burst got %b exp 11", {bus.gnt0, bus.out_valid});
    end
`ifdef ARB_STATS_EN
    checks++;
    if ({gnt_cnt0, gnt_cnt1} !== {16'd3, 16'd0}) begin
      errors++;
      $display("FAIL stats_count got %0d/%0d exp 3/0", gnt_cnt0, gnt_cnt1);
    end
`endif
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.sel, bus.out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_async got %b exp 0000", {bus.gnt0, bus.gnt1, bus.sel, bus.out_valid});
    end
`ifdef ARB_STATS_EN
    checks++;
    if (gnt_cnt0 !== 16'd0) begin
      errors++;
      $display("FAIL stats_clear got %0d exp 0", gnt_cnt0);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single();
    test_round_robin();
    test_max_beats();
    test_stall();
    test_abandon();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
